// File: rtl/sccb_config_sequencer.sv
// Camera register-table sequencer: walks a sync ROM, issues SCCB writes with
// NACK retry, executes programmable delays, and stops at an end marker or table end.
//
// state    | meaning
// IDLE     | waiting for start after reset
// FETCH    | rom_addr presented, ROM read in flight
// DECODE   | rom_data classified as write, delay or end marker
// WRITE    | wr_valid held until the master accepts
// WAIT_ACK | waiting for wr_done, retry on NACK
// DELAY    | delay down-counter running
// FINISH   | table complete, done held
// FAIL     | retries exhausted, error held
module sccb_config_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int REG_W      = 8,
  parameter int VAL_W      = 8,
  parameter int DELAY_UNIT = 1024,
  parameter int MAX_RETRY  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [REG_W+VAL_W-1:0] rom_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [REG_W-1:0]       wr_reg,
  output logic [VAL_W-1:0]       wr_val,
  input  logic                   wr_done,
  input  logic                   wr_nack,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_W-1:0]      err_index
);

  localparam int CW = VAL_W + $clog2(DELAY_UNIT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_WAIT_ACK, S_DELAY, S_FINISH, S_FAIL
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] index;
  logic [3:0]        retry;
  logic [CW-1:0]     dly_cnt;
  logic [CW-1:0]     dly_load;
  logic [REG_W-1:0]  rom_reg;
  logic [VAL_W-1:0]  rom_val;
  logic              is_marker, is_end, dly_tc, last, can_retry;

  assign rom_reg   = rom_data[REG_W+VAL_W-1:VAL_W];
  assign rom_val   = rom_data[VAL_W-1:0];
  assign is_marker = &rom_reg;
  assign is_end    = is_marker & (&rom_val);
  assign dly_tc    = (dly_cnt == '0);
  assign last      = (index == '1);
  assign can_retry = (retry < 4'(MAX_RETRY));
  assign rom_addr  = index;

  // Loaded as total-1 so the FETCH after the delay lands exactly (val+1)*DELAY_UNIT later.
  assign dly_load = (CW'(rom_val) + CW'(1)) * CW'(DELAY_UNIT) - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FINISH, S_FAIL: if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (!is_marker)  state_nxt = S_WRITE;
        else if (is_end) state_nxt = S_FINISH;
        else             state_nxt = S_DELAY;
      end
      S_WRITE: if (wr_ready) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (wr_done) begin
          if (!wr_nack)       state_nxt = last ? S_FINISH : S_FETCH;
          else if (can_retry) state_nxt = S_WRITE;
          else                state_nxt = S_FAIL;
        end
      end
      S_DELAY: if (dly_tc) state_nxt = last ? S_FINISH : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      retry     <= '0;
      dly_cnt   <= '0;
      wr_reg    <= '0;
      wr_val    <= '0;
      err_index <= '0;
    end else begin
      case (state)
        S_IDLE, S_FINISH, S_FAIL: begin
          if (start) begin
            index <= '0;
            retry <= '0;
          end
        end
        S_DECODE: begin
          if (!is_marker) begin
            wr_reg <= rom_reg;
            wr_val <= rom_val;
          end else if (!is_end) begin
            dly_cnt <= dly_load;
          end
        end
        S_WAIT_ACK: begin
          if (wr_done) begin
            if (!wr_nack) begin
              retry <= '0;
              if (!last) index <= index + 1'b1;
            end else if (can_retry) begin
              retry <= retry + 1'b1;
            end else begin
              err_index <= index;
            end
          end
        end
        S_DELAY: begin
          if (dly_tc) begin
            retry <= '0;
            if (!last) index <= index + 1'b1;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_WRITE:  wr_valid = 1'b1;
      S_FINISH: begin busy = 1'b0; done = 1'b1; end
      S_FAIL:   begin busy = 1'b0; error = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench: main instance (DELAY_UNIT=4) plus a 4-entry instance for the
// no-end-marker / restart cases, each with a small write-master responder.
module tb_sccb_config_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  always #5 clk = ~clk;

  // main instance
  logic [7:0]  rom_addr, err_index;
  logic [15:0] rom_data;
  logic        wr_valid, wr_ready, wr_done, wr_nack, busy, done, error;
  logic [7:0]  wr_reg, wr_val;
  logic [15:0] rom1 [256];

  sccb_config_sequencer #(.ADDR_W(8), .REG_W(8), .VAL_W(8), .DELAY_UNIT(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_reg(wr_reg), .wr_val(wr_val),
    .wr_done(wr_done), .wr_nack(wr_nack), .busy(busy), .done(done), .error(error),
    .err_index(err_index)
  );

  always @(posedge clk) rom_data <= rom1[rom_addr];

  // small-table instance
  logic [1:0]  rom_addr2, err_index2;
  logic [15:0] rom_data2;
  logic        wr_valid2, wr_ready2, wr_done2, wr_nack2, busy2, done2, error2;
  logic [7:0]  wr_reg2, wr_val2;
  logic [15:0] rom2 [4];

  sccb_config_sequencer #(.ADDR_W(2), .REG_W(8), .VAL_W(8), .DELAY_UNIT(1), .MAX_RETRY(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_reg(wr_reg2), .wr_val(wr_val2),
    .wr_done(wr_done2), .wr_nack(wr_nack2), .busy(busy2), .done(done2), .error(error2),
    .err_index(err_index2)
  );

  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // main responder: ready after ready_gap cycles, done 4 cycles after accept
  int          ready_gap = 0;
  logic [7:0]  nack_reg = 8'h00;
  int          nack_limit = 0;
  int          nack_given = 0;
  int          hs_cnt = 0;
  int          proto_err = 0;
  int          hs_by_reg [256];
  logic [15:0] last_pair = 16'h0;

  initial begin
    logic [7:0] cap_reg, cap_val;
    for (int i = 0; i < 256; i++) hs_by_reg[i] = 0;
    wr_ready = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_valid && !rst) begin
        cap_reg = wr_reg;
        cap_val = wr_val;
        for (int i = 0; i < ready_gap; i++) begin
          @(negedge clk);
          if (!wr_valid || wr_reg !== cap_reg || wr_val !== cap_val) proto_err++;
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        if (wr_valid) proto_err++;
        hs_cnt++;
        hs_by_reg[cap_reg]++;
        last_pair = {cap_reg, cap_val};
        repeat (3) @(negedge clk);
        wr_nack = (cap_reg == nack_reg) && (nack_given < nack_limit);
        if (wr_nack) nack_given++;
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        wr_nack = 1'b0;
      end
    end
  end

  // small-table responder: ready tied high, done 2 cycles after accept
  int hs2 = 0;
  initial begin
    wr_ready2 = 1'b1; wr_done2 = 1'b0; wr_nack2 = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_valid2 && !rst) begin
        hs2++;
        @(negedge clk);
        @(negedge clk);
        wr_done2 = 1'b1;
        @(negedge clk);
        wr_done2 = 1'b0;
      end
    end
  end

  // rom_addr2 must never move backwards while a sequence runs
  int         wrap2 = 0;
  logic [1:0] prev2 = 2'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (busy2) begin
        if (rom_addr2 < prev2) wrap2++;
        prev2 = rom_addr2;
      end else begin
        prev2 = 2'd0;
      end
    end
  end

  task automatic pulse1();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse2();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
  endtask

  task automatic wait_idle1(input int max_cyc, output logic to);
    int c;
    c = 0; to = 1'b0;
    while (busy) begin
      @(negedge clk);
      c++;
      if (c >= max_cyc) begin to = 1'b1; break; end
    end
  endtask

  task automatic wait_idle2(input int max_cyc, output logic to);
    int c;
    c = 0; to = 1'b0;
    while (busy2) begin
      @(negedge clk);
      c++;
      if (c >= max_cyc) begin to = 1'b1; break; end
    end
  endtask

  initial begin
    logic to;
    int   h0, h33, h44, h55, pe0, cnt, first_a1;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 256; i++) rom1[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++)   rom2[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_val("rst_outputs", {busy, done, error, wr_valid}, 4'b0000);
    check_val("rst_addr", {rom_addr, err_index, wr_reg, wr_val}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // two plain writes, wr_valid latency from start
    rom1[0] = 16'h1280; rom1[1] = 16'h1180; rom1[2] = 16'hFFFF;
    h0 = hs_cnt;
    pulse1();
    check_val("t1_busy_addr", {busy, rom_addr}, {1'b1, 8'h00});
    cnt = 0;
    while (!wr_valid && cnt < 20) begin @(negedge clk); cnt++; end
    check_val("t1_valid_lat", cnt, 2);
    check_val("t1_first_wr", {wr_reg, wr_val}, 16'h1280);
    wait_idle1(500, to);
    check_val("t1_timeout", to, 0);
    check_val("t1_done", {done, error, busy}, 3'b100);
    check_val("t1_handshakes", hs_cnt - h0, 2);
    check_val("t1_last_pair", last_pair, 16'h1180);
    check_val("t1_end_addr", rom_addr, 8'h02);

    // delay entry: (2+1)*4 = 12 cycles, then write 40/D0
    rom1[0] = 16'hFF02; rom1[1] = 16'h40D0; rom1[2] = 16'hFFFF;
    pulse1();
    check_val("t2_done_clr", done, 0);
    cnt = 0; first_a1 = -1;
    while (!wr_valid && cnt < 100) begin
      @(negedge clk); cnt++;
      if (rom_addr == 8'h01 && first_a1 < 0) first_a1 = cnt;
    end
    check_val("t2_fetch1_cyc", first_a1, 14);
    check_val("t2_valid_cyc", cnt, 16);
    check_val("t2_wr", {wr_reg, wr_val}, 16'h40D0);
    wait_idle1(500, to);
    check_val("t2_done", {to, done}, 2'b01);

    // ready held low 7 cycles: stable request, single acceptance
    rom1[0] = 16'h2A5C; rom1[1] = 16'hFFFF;
    ready_gap = 7; h0 = hs_cnt; pe0 = proto_err;
    pulse1();
    wait_idle1(500, to);
    ready_gap = 0;
    check_val("t3_stable", proto_err - pe0, 0);
    check_val("t3_handshakes", hs_cnt - h0, 1);
    check_val("t3_done", {to, done}, 2'b01);

    // entry 3 NACKs twice then ACKs
    rom1[0] = 16'h0111; rom1[1] = 16'h0222; rom1[2] = 16'h0333;
    rom1[3] = 16'h335A; rom1[4] = 16'h44A5; rom1[5] = 16'hFFFF;
    nack_reg = 8'h33; nack_limit = nack_given + 2;
    h0 = hs_cnt; h33 = hs_by_reg[8'h33]; h44 = hs_by_reg[8'h44];
    pulse1();
    wait_idle1(1000, to);
    check_val("t4_timeout", to, 0);
    check_val("t4_req_e3", hs_by_reg[8'h33] - h33, 3);
    check_val("t4_total", hs_cnt - h0, 7);
    check_val("t4_done", {done, error}, 2'b10);

    // entry 3 NACKs four times: retries exhausted
    nack_limit = nack_given + 4;
    h0 = hs_cnt; h33 = hs_by_reg[8'h33]; h44 = hs_by_reg[8'h44];
    pulse1();
    wait_idle1(1000, to);
    repeat (6) @(negedge clk);
    check_val("t4f_timeout", to, 0);
    check_val("t4f_flags", {error, done, busy}, 3'b100);
    check_val("t4f_err_index", err_index, 8'h03);
    check_val("t4f_req_e3", hs_by_reg[8'h33] - h33, 4);
    check_val("t4f_req_e4", hs_by_reg[8'h44] - h44, 0);

    // reset in the middle of a 1000-cycle delay
    rom1[0] = 16'hFFF9; rom1[1] = 16'h55AA; rom1[2] = 16'hFFFF;
    nack_limit = nack_given;
    h55 = hs_by_reg[8'h55];
    pulse1();
    repeat (20) @(negedge clk);
    check_val("t5_in_delay", {busy, error}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check_val("t5_rst_flags", {busy, done, error, wr_valid}, 4'b0000);
    check_val("t5_rst_regs", {rom_addr, err_index, wr_reg, wr_val}, 32'h0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_val("t5_no_write", {busy, 8'(hs_by_reg[8'h55] - h55)}, 9'h0);
    pulse1();
    check_val("t5_restart", {busy, rom_addr}, {1'b1, 8'h00});
    wait_idle1(2000, to);
    check_val("t5_done", {to, done}, 2'b01);
    check_val("t5_write", hs_by_reg[8'h55] - h55, 1);

    // 4-entry table without end marker, start while busy, rerun
    rom2[0] = 16'hA101; rom2[1] = 16'hA202; rom2[2] = 16'hA303; rom2[3] = 16'hA404;
    pulse2();
    check_val("t6_busy", busy2, 1);
    repeat (6) @(negedge clk);
    pulse2();
    wait_idle2(300, to);
    check_val("t6_timeout", to, 0);
    check_val("t6_writes", hs2, 4);
    check_val("t6_flags", {done2, error2}, 2'b10);
    check_val("t6_no_wrap", {wrap2, rom_addr2}, {32'd0, 2'd3});
    pulse2();
    check_val("t6_rerun", {done2, busy2}, 2'b01);
    wait_idle2(300, to);
    check_val("t6_rerun_done", {to, done2}, 2'b01);
    check_val("t6_rerun_writes", hs2, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
